// File: rtl/ifu_fetch.sv
// rtl/ifu_fetch.sv - instruction fetch unit
// One imem request in flight at a time; the fetched word is buffered until idu takes it.
module ifu_fetch (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        ins_valid,
  input  logic        ins_ready,
  output logic [31:0] ins,
  output logic [63:0] ins_pc
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_e;

  localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;

  state_e      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic        kill_q, kill_d;
  logic [31:0] ins_q, ins_d;
  logic [63:0] ins_pc_q, ins_pc_d;
  logic [63:0] redirect_target;
  logic        unused_redirect_lsbs;

  assign redirect_target      = {redirect_pc[63:2], 2'b00};
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    kill_d   = kill_q;
    ins_d    = ins_q;
    ins_pc_d = ins_pc_q;
    case (state_q)
      S_REQ: begin
        // A request accepted alongside a redirect fetches a stale address; mark it for discard.
        if (imem_req_ready) begin
          state_d = S_WAIT;
          kill_d  = redirect_valid;
        end
      end
      S_WAIT: begin
        if (imem_rsp_valid) begin
          kill_d = 1'b0;
          if (kill_q || redirect_valid) begin
            state_d = S_REQ;
          end else begin
            ins_d    = imem_rsp_data;
            ins_pc_d = pc_q;
            state_d  = S_HOLD;
          end
        end else if (redirect_valid) begin
          kill_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (redirect_valid || ins_ready) begin
          state_d = S_REQ;
          if (!redirect_valid) begin
            pc_d = pc_q + 64'd4;
          end
        end
      end
      default: begin
        state_d = S_REQ;
      end
    endcase
    if (redirect_valid) begin
      pc_d = redirect_target;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_REQ;
      pc_q     <= RESET_PC;
      kill_q   <= 1'b0;
      ins_q    <= 32'h0;
      ins_pc_q <= 64'h0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      kill_q   <= kill_d;
      ins_q    <= ins_d;
      ins_pc_q <= ins_pc_d;
    end
  end

  assign imem_req_valid = (state_q == S_REQ);
  assign imem_req_addr  = pc_q;
  assign ins_valid      = (state_q == S_HOLD);
  assign ins            = ins_q;
  assign ins_pc         = ins_pc_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// tb/tb_ifu_fetch.sv - directed and randomized checks of ifu_fetch
// Reference model tracks the architectural next pc; the bench acts as imem.
module tb_ifu_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        ins_valid;
  logic        ins_ready;
  logic [31:0] ins;
  logic [63:0] ins_pc;

  always #5 clk = ~clk;

  ifu_fetch dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .ins_valid      (ins_valid),
    .ins_ready      (ins_ready),
    .ins            (ins),
    .ins_pc         (ins_pc)
  );

  int          checks = 0;
  int          errors = 0;
  logic [63:0] exp_pc;
  logic        mem_busy;
  logic [63:0] mem_addr;
  int          mem_cnt;
  int          mem_delay;
  int          cyc;
  int          delivered = 0;
  int          iv_cyc[$];
  logic [63:0] iv_pc[$];

  function automatic logic [31:0] memf(input logic [63:0] a);
    return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  // One clock cycle: check outputs, act as memory, drive inputs, advance the model.
  task automatic run_cycle(input logic rr, input logic ir, input logic rd, input logic [63:0] rt);
    logic rsp;
    if (imem_req_valid) check("req_addr", imem_req_addr, exp_pc);
    if (ins_valid) begin
      check("ins_pc", ins_pc, exp_pc);
      check("ins_data", {32'h0, ins}, {32'h0, memf(exp_pc)});
      iv_cyc.push_back(cyc);
      iv_pc.push_back(ins_pc);
    end
    check("req_and_ins_valid", {63'h0, imem_req_valid & ins_valid}, 64'h0);
    rsp = mem_busy && (mem_cnt == 0);
    imem_rsp_valid = rsp;
    imem_rsp_data  = rsp ? memf(mem_addr) : $urandom;
    imem_req_ready = rr;
    ins_ready      = ir;
    redirect_valid = rd;
    redirect_pc    = rt;
    if (rsp) mem_busy = 1'b0;
    else if (mem_busy) mem_cnt--;
    if (imem_req_valid && rr) begin
      mem_busy = 1'b1;
      mem_addr = imem_req_addr;
      mem_cnt  = mem_delay - 1;
    end
    if (rd) exp_pc = {rt[63:2], 2'b00};
    else if (ins_valid && ir) begin
      exp_pc = exp_pc + 64'd4;
      delivered++;
    end
    @(posedge clk);
    #1;
    cyc++;
    imem_rsp_valid = 1'b0;
    redirect_valid = 1'b0;
  endtask

  task automatic wait_ins();
    int n = 0;
    while (!ins_valid && n < 40) begin
      run_cycle(1'b1, 1'b0, 1'b0, 64'h0);
      n++;
    end
    check("wait_ins_timeout", {63'h0, ins_valid}, 64'h1);
  endtask

  task automatic wait_req();
    int n = 0;
    while (!imem_req_valid && n < 40) begin
      run_cycle(1'b0, 1'b1, 1'b0, 64'h0);
      n++;
    end
    check("wait_req_timeout", {63'h0, imem_req_valid}, 64'h1);
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    ins_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 64'h0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_valid", {63'h0, imem_req_valid}, 64'h1);
    check("rst_req_addr", imem_req_addr, 64'h8000_0000);
    check("rst_ins_valid", {63'h0, ins_valid}, 64'h0);
    check("rst_ins", {32'h0, ins}, 64'h0);
    check("rst_ins_pc", ins_pc, 64'h0);
    rst_n    = 1'b1;
    exp_pc   = 64'h8000_0000;
    mem_busy = 1'b0;
    mem_cnt  = 0;
    check("post_rst_req_valid", {63'h0, imem_req_valid}, 64'h1);
    check("post_rst_req_addr", imem_req_addr, 64'h8000_0000);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] held_ins;
    logic [63:0] held_pc;
    logic [63:0] rt;
    int          d0;

    mem_delay = 1;
    do_reset();

    // straight-line fetch
    cyc = 0;
    iv_cyc.delete();
    iv_pc.delete();
    repeat (9) run_cycle(1'b1, 1'b1, 1'b0, 64'h0);
    check("line_ins_count", 64'(iv_cyc.size()), 64'd3);
    for (int i = 0; i < iv_cyc.size() && i < 3; i++) begin
      check("line_ins_cycle", 64'(iv_cyc[i]), 64'(2 + 3 * i));
      check("line_ins_pc", iv_pc[i], 64'h8000_0000 + 64'(4 * i));
    end

    // idu backpressure
    wait_ins();
    held_ins = ins;
    held_pc  = ins_pc;
    check("bp_pc", held_pc, 64'h8000_000C);
    repeat (5) begin
      run_cycle(1'b1, 1'b0, 1'b0, 64'h0);
      check("bp_ins_stable", {32'h0, ins}, {32'h0, held_ins});
      check("bp_pc_stable", ins_pc, held_pc);
      check("bp_no_req", {63'h0, imem_req_valid}, 64'h0);
    end
    run_cycle(1'b1, 1'b1, 1'b0, 64'h0);
    check("bp_release_req", {63'h0, imem_req_valid}, 64'h1);
    check("bp_release_addr", imem_req_addr, held_pc + 64'd4);

    // redirect while waiting for the response
    mem_delay = 2;
    check("wr_pre_addr", imem_req_addr, 64'h8000_0010);
    run_cycle(1'b1, 1'b1, 1'b0, 64'h0);
    run_cycle(1'b1, 1'b1, 1'b1, 64'h8000_0103);
    wait_req();
    check("wr_req_addr", imem_req_addr, 64'h8000_0100);
    mem_delay = 1;
    wait_ins();
    check("wr_ins_pc", ins_pc, 64'h8000_0100);

    // redirect and ins_ready together in HOLD
    run_cycle(1'b1, 1'b1, 1'b1, 64'h8000_0200);
    check("hr_req_valid", {63'h0, imem_req_valid}, 64'h1);
    check("hr_req_addr", imem_req_addr, 64'h8000_0200);

    // memory stalls
    repeat (3) begin
      run_cycle(1'b0, 1'b1, 1'b0, 64'h0);
      check("st_req_valid", {63'h0, imem_req_valid}, 64'h1);
      check("st_addr_held", imem_req_addr, 64'h8000_0200);
    end
    mem_delay = 4;
    run_cycle(1'b1, 1'b0, 1'b0, 64'h0);
    repeat (4) begin
      check("st_wait_no_ins", {63'h0, ins_valid}, 64'h0);
      run_cycle(1'b1, 1'b0, 1'b0, 64'h0);
    end
    check("st_ins_valid", {63'h0, ins_valid}, 64'h1);
    check("st_ins_pc", ins_pc, 64'h8000_0200);
    repeat (3) begin
      run_cycle(1'b1, 1'b0, 1'b0, 64'h0);
      check("st_hold_valid", {63'h0, ins_valid}, 64'h1);
      check("st_hold_no_req", {63'h0, imem_req_valid}, 64'h0);
    end
    d0 = delivered;
    run_cycle(1'b0, 1'b1, 1'b0, 64'h0);
    check("st_one_delivered", 64'(delivered - d0), 64'd1);
    check("st_after_no_ins", {63'h0, ins_valid}, 64'h0);

    // redirect in REQ without handshake, then 64-bit wrap of pc+4
    mem_delay = 1;
    run_cycle(1'b0, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
    check("wrap_redirect_addr", imem_req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    wait_ins();
    run_cycle(1'b0, 1'b1, 1'b0, 64'h0);
    check("wrap_req_addr", imem_req_addr, 64'h0);

    // reset in WAIT, then a stray response
    mem_delay = 3;
    run_cycle(1'b1, 1'b0, 1'b0, 64'h0);
    rst_n = 1'b0;
    #1;
    check("arst_req_valid", {63'h0, imem_req_valid}, 64'h1);
    check("arst_req_addr", imem_req_addr, 64'h8000_0000);
    do_reset();
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hDEAD_BEEF;
    imem_req_ready = 1'b0;
    @(posedge clk);
    #1;
    imem_rsp_valid = 1'b0;
    check("stray_req_valid", {63'h0, imem_req_valid}, 64'h1);
    check("stray_req_addr", imem_req_addr, 64'h8000_0000);
    check("stray_no_ins", {63'h0, ins_valid}, 64'h0);
    mem_delay = 1;
    wait_ins();
    check("stray_first_pc", ins_pc, 64'h8000_0000);

    // randomized traffic
    d0 = delivered;
    for (int i = 0; i < 3000; i++) begin
      mem_delay = $urandom_range(1, 3);
      rt = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 1) rt = {32'h0, 32'h8000_0000 | ($urandom & 32'h0000_0FFF)};
      run_cycle($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                $urandom_range(0, 11) == 0, rt);
    end
    check("rand_progress", {63'h0, (delivered - d0) > 100}, 64'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
